// File: rtl/wisc_pkg.sv
// wisc_pkg: WISC-F18 opcodes, flag bit indices and flag-class helpers.
package wisc_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

    function automatic logic sets_zvn(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

    function automatic logic sets_z_only(input logic [3:0] op);
        return op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR;
    endfunction
endpackage

// File: rtl/ex_flag_stage_if.sv
// ex_flag_stage_if: ALU-to-stage input bus plus registered MEM-side outputs and flags.
interface ex_flag_stage_if #(parameter int DATA_W = 16, parameter int REG_AW = 4);
    logic              in_valid;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovf;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic              flag_z;
    logic              flag_v;
    logic              flag_n;

    modport master (
        output in_valid, opcode, alu_out, alu_ovf, rd, reg_write,
        input  out_valid, out_result, out_rd, out_reg_write, flag_z, flag_v, flag_n
    );

    modport slave (
        input  in_valid, opcode, alu_out, alu_ovf, rd, reg_write,
        output out_valid, out_result, out_rd, out_reg_write, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/ex_flag_stage_flag_calc.sv
// flag_calc: next Z/V/N values and update enable for the executing opcode.
module flag_calc
    import wisc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovf,
    input  logic [FLAG_W-1:0] flags,
    output logic [FLAG_W-1:0] next_flags,
    output logic              update
);
    logic all_flags;
    logic z_only;

    always_comb begin
        all_flags  = sets_zvn(opcode);
        z_only     = sets_z_only(opcode);
        update     = all_flags | z_only;
        next_flags = flags;
        next_flags[FLAG_Z] = update ? (alu_out == '0) : flags[FLAG_Z];
        next_flags[FLAG_V] = all_flags ? alu_ovf : flags[FLAG_V];
        next_flags[FLAG_N] = all_flags ? alu_out[DATA_W-1] : flags[FLAG_N];
    end
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX/MEM pipeline register with architectural Z/V/N flags (rst > flush > stall > accept).
module ex_flag_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input logic clk,
    input logic rst,
    input logic stall,
    input logic flush,
    ex_flag_stage_if.slave bus
);
    logic              valid_q;
    logic              we_q;
    logic [DATA_W-1:0] result_q;
    logic [REG_AW-1:0] rd_q;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] next_flags;
    logic              update;

    flag_calc #(.DATA_W(DATA_W)) u_flag_calc (
        .opcode     (bus.opcode),
        .alu_out    (bus.alu_out),
        .alu_ovf    (bus.alu_ovf),
        .flags      (flags_q),
        .next_flags (next_flags),
        .update     (update)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            flags_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (!stall) begin
            valid_q <= bus.in_valid;
            we_q    <= bus.in_valid & bus.reg_write;
            if (bus.in_valid) begin
                result_q <= bus.alu_out;
                rd_q     <= bus.rd;
            end
            if (bus.in_valid && update)
                flags_q <= next_flags;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_reg_write = we_q;
    assign bus.out_result    = result_q;
    assign bus.out_rd        = rd_q;
    assign bus.flag_z        = flags_q[FLAG_Z];
    assign bus.flag_v        = flags_q[FLAG_V];
    assign bus.flag_n        = flags_q[FLAG_N];
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: scoreboard bench, directed flag scenarios then random traffic vs. a reference model.
module tb_ex_flag_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int total = 0;
    int bad = 0;
    bit done = 1'b0;

    typedef struct {
        logic        valid;
        logic        we;
        logic [15:0] res;
        logic [3:0]  rd;
        logic        known;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    exp_t m;
    exp_t q[$];

    ex_flag_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

    ex_flag_stage #(.DATA_W(16), .REG_AW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference: what the stage must hold after one edge with the given controls.
    task automatic model(input logic r, input logic s, input logic f, input logic iv,
                         input logic [3:0] op, input logic [15:0] a, input logic ov,
                         input logic [3:0] d, input logic w);
        if (r) begin
            m = '{valid: 1'b0, we: 1'b0, res: 16'h0, rd: 4'h0, known: 1'b1, z: 1'b0, v: 1'b0, n: 1'b0};
        end else if (f) begin
            m.valid = 1'b0;
            m.we = 1'b0;
            m.known = 1'b0;
        end else if (!s) begin
            if (iv) begin
                m.valid = 1'b1;
                m.we = w;
                m.res = a;
                m.rd = d;
                m.known = 1'b1;
                if (op == 4'h0 || op == 4'h1) begin
                    m.z = (a == 16'h0);
                    m.n = a[15];
                    m.v = ov;
                end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
                    m.z = (a == 16'h0);
                end
            end else begin
                m.valid = 1'b0;
                m.we = 1'b0;
                m.known = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic f, input logic iv,
                         input logic [3:0] op, input logic [15:0] a, input logic ov,
                         input logic [3:0] d, input logic w);
        @(negedge clk);
        rst = r;
        stall = s;
        flush = f;
        bus.in_valid = iv;
        bus.opcode = op;
        bus.alu_out = a;
        bus.alu_ovf = ov;
        bus.rd = d;
        bus.reg_write = w;
        @(posedge clk);
        model(r, s, f, iv, op, a, ov, d, w);
        q.push_back(m);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 16'(bus.out_valid), 16'(e.valid));
            chk("out_reg_write", 16'(bus.out_reg_write), 16'(e.we));
            chk("flag_z", 16'(bus.flag_z), 16'(e.z));
            chk("flag_v", 16'(bus.flag_v), 16'(e.v));
            chk("flag_n", 16'(bus.flag_n), 16'(e.n));
            if (e.known) begin
                chk("out_result", bus.out_result, e.res);
                chk("out_rd", 16'(bus.out_rd), 16'(e.rd));
            end
        end
    end

    initial begin
        logic r, s, f, iv, ov, w;
        logic [3:0] op, d;
        logic [15:0] a;
        m = '{valid: 1'b0, we: 1'b0, res: 16'h0, rd: 4'h0, known: 1'b0, z: 1'b0, v: 1'b0, n: 1'b0};
        bus.in_valid = 1'b0;
        bus.opcode = 4'h0;
        bus.alu_out = 16'h0;
        bus.alu_ovf = 1'b0;
        bus.rd = 4'h0;
        bus.reg_write = 1'b0;
        // Reset with every other control active.
        cycle(1, 1, 1, 1, 4'h0, 16'h5555, 1, 4'h3, 1);
        cycle(1, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 0);
        // SRA with all flags previously set.
        cycle(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'h1, 1);
        cycle(0, 0, 0, 1, 4'h2, 16'h0000, 0, 4'h2, 1);
        cycle(0, 0, 0, 1, 4'h5, 16'hFFFF, 0, 4'h3, 1);
        // ADD overflow then SUB to zero.
        cycle(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'h4, 1);
        cycle(0, 0, 0, 1, 4'h1, 16'h0000, 0, 4'h5, 0);
        // LW after Z=0,V=1,N=1 leaves flags.
        cycle(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'h6, 1);
        cycle(0, 0, 0, 1, 4'h8, 16'h0000, 0, 4'h7, 1);
        // Flush beats stall, then stall holds.
        cycle(0, 1, 1, 1, 4'h2, 16'h0000, 0, 4'h8, 1);
        cycle(0, 0, 0, 1, 4'h9, 16'hABCD, 0, 4'h9, 1);
        cycle(0, 1, 0, 1, 4'h2, 16'h0000, 0, 4'hA, 1);
        cycle(0, 1, 0, 1, 4'h0, 16'h0000, 0, 4'hB, 0);
        // Reset mid-stall, then SLL zero.
        cycle(0, 0, 0, 1, 4'h0, 16'h1234, 0, 4'hC, 1);
        cycle(0, 1, 0, 1, 4'h0, 16'h1234, 0, 4'hC, 1);
        cycle(1, 1, 0, 1, 4'h0, 16'h1234, 0, 4'hC, 1);
        cycle(0, 0, 0, 1, 4'h4, 16'h0000, 0, 4'hD, 1);
        cycle(0, 0, 0, 0, 4'h0, 16'h7777, 1, 4'hE, 1);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(99) < 3);
            s  = ($urandom_range(99) < 20);
            f  = ($urandom_range(99) < 10);
            iv = ($urandom_range(99) < 80);
            op = 4'($urandom_range(15));
            a  = ($urandom_range(99) < 20) ? 16'h0 : 16'($urandom);
            ov = 1'($urandom_range(1));
            d  = 4'($urandom_range(15));
            w  = 1'($urandom_range(1));
            cycle(r, s, f, iv, op, a, ov, d, w);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
